// File: rtl/sequencer_cmd_pkg.sv
// Command vocabulary shared by the sequencer host controller: opcodes,
// response codes, controller states, and the limits applied to settings.
// Ports: none (package).
package sequencer_cmd_pkg;

  // Host opcodes
  localparam logic [7:0] OP_CAM_MS         = 8'h01;
  localparam logic [7:0] OP_GALVO_MS       = 8'h02;
  localparam logic [7:0] OP_NUM_IMAGES     = 8'h03;
  localparam logic [7:0] OP_CYCLES         = 8'h04;
  localparam logic [7:0] OP_GALVO_POS      = 8'h05;
  localparam logic [7:0] OP_START_NO_GALVO = 8'h10;
  localparam logic [7:0] OP_START_GALVO    = 8'h11;
  localparam logic [7:0] OP_STATUS         = 8'h20;

  // Response bytes
  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;

  // Limits
  localparam int MAX_IMAGES = 64;
  localparam int BUSY_WAIT  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_EXEC,
    ST_START,
    ST_WAIT_BUSY,
    ST_RESPOND
  } state_t;

  function automatic logic opcode_known(input logic [7:0] op);
    case (op)
      OP_CAM_MS, OP_GALVO_MS, OP_NUM_IMAGES, OP_CYCLES, OP_GALVO_POS,
      OP_START_NO_GALVO, OP_START_GALVO, OP_STATUS: opcode_known = 1'b1;
      default:                                      opcode_known = 1'b0;
    endcase
  endfunction

  // Number of little-endian payload bytes following an opcode.
  function automatic logic [2:0] payload_len(input logic [7:0] op);
    case (op)
      OP_CAM_MS, OP_GALVO_MS, OP_NUM_IMAGES: payload_len = 3'd1;
      OP_CYCLES:                             payload_len = 3'd2;
      OP_GALVO_POS:                          payload_len = 3'd4;
      default:                               payload_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/byte_gap_timer.sv
// Inter-byte gap timer: counts while enabled, pulses expired for one cycle.
// Latency: expired asserts combinationally on the cycle count == TIMEOUT_CYCLES-1.
// Backpressure: none; clear has priority over counting.
// Ports: iCLK/iRST clock and async active-high reset; clear restarts the
//        count; enable lets it advance; expired is the single-cycle timeout.
module byte_gap_timer #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expired = enable && (count == LAST);

  // Restart after expiry so a stale count never leaks into the next command.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      count <= '0;
    end else if (clear || expired) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sequencer_host_controller.sv
// Host command parser: UART bytes -> sequencer settings, start pulses, status.
// Latency: last byte at N -> exec N+1 -> response/register update N+2; start ACK >= N+4.
// Backpressure: rx ready only while parsing; a response holds until iTX_READY.
// Ports: iRX_VALID/iRX_DATA/oRX_READY receive stream; oTX_VALID/oTX_DATA/
//        iTX_READY response stream; o*_MILLISEC, oNUM_*, oCYCLES_* settings and
//        oTRIG_* start pulses to the sequencer; iSEQ_BUSY/iFRAME_ID its status.
module sequencer_host_controller
  import sequencer_cmd_pkg::*;
#(
  parameter logic [7:0]  DEFAULT_CAM_MS     = 8'd10,
  parameter logic [7:0]  DEFAULT_GALVO_MS   = 8'd5,
  parameter logic [6:0]  DEFAULT_NUM_IMAGES = 7'd1,
  parameter logic [15:0] DEFAULT_CYCLES     = 16'd1,
  parameter logic [31:0] DEFAULT_GALVO_POS  = 32'd1,
  parameter int          TIMEOUT_CYCLES     = 50_000_000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iRX_VALID,
  input  logic [7:0]  iRX_DATA,
  output logic        oRX_READY,
  output logic        oTX_VALID,
  output logic [7:0]  oTX_DATA,
  input  logic        iTX_READY,
  output logic [7:0]  oCAMERA_TRIGGER_MILLISEC,
  output logic [7:0]  oGALVO_TRIGGER_MILLISEC,
  output logic [6:0]  oNUM_SLM_IMAGES,
  output logic [15:0] oCYCLES_OF_DISPLAY_FOR_EACH_IMAGE,
  output logic [31:0] oNUM_OF_GALVO_POSITIONS,
  output logic        oTRIG_WITHOUT_GALVO,
  output logic        oTRIG_WITH_GALVO,
  input  logic        iSEQ_BUSY,
  input  logic [5:0]  iFRAME_ID
);

  state_t      state, state_nxt;
  logic [7:0]  opcode;
  logic [31:0] payload;
  logic [1:0]  byte_idx;
  logic [1:0]  wait_cnt;
  logic [7:0]  tx_dat;

  logic [7:0]  cam_ms, galvo_ms;
  logic [6:0]  num_images;
  logic [15:0] cycles;
  logic [31:0] galvo_pos;

  logic rx_fire;
  logic gap_expired;
  logic is_write, is_start, write_legal;

  // Comb outputs of the FSM
  logic       tx_load;
  logic [7:0] tx_nxt;
  logic       write_en;
  logic       trig_with, trig_without;

  assign oRX_READY = (state == ST_IDLE) || (state == ST_PAYLOAD);
  assign rx_fire   = iRX_VALID && oRX_READY;
  assign oTX_VALID = (state == ST_RESPOND);
  assign oTX_DATA  = tx_dat;

  assign oCAMERA_TRIGGER_MILLISEC          = cam_ms;
  assign oGALVO_TRIGGER_MILLISEC           = galvo_ms;
  assign oNUM_SLM_IMAGES                   = num_images;
  assign oCYCLES_OF_DISPLAY_FOR_EACH_IMAGE = cycles;
  assign oNUM_OF_GALVO_POSITIONS           = galvo_pos;
  assign oTRIG_WITH_GALVO                  = trig_with;
  assign oTRIG_WITHOUT_GALVO               = trig_without;

  byte_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .clear   (rx_fire),
    .enable  (state == ST_PAYLOAD),
    .expired (gap_expired)
  );

  assign is_write = (opcode == OP_CAM_MS) || (opcode == OP_GALVO_MS) ||
                    (opcode == OP_NUM_IMAGES) || (opcode == OP_CYCLES) ||
                    (opcode == OP_GALVO_POS);
  assign is_start = (opcode == OP_START_NO_GALVO) || (opcode == OP_START_GALVO);

  // Range checks on the collected payload for the current write opcode.
  always_comb begin
    write_legal = 1'b0;
    case (opcode)
      OP_CAM_MS, OP_GALVO_MS: write_legal = (payload[7:0] != 8'd0);
      OP_NUM_IMAGES:          write_legal = (payload[6:0] != 7'd0) &&
                                            (payload[6:0] <= 7'(MAX_IMAGES));
      OP_CYCLES:              write_legal = (payload[15:0] != 16'd0);
      OP_GALVO_POS:           write_legal = (payload != 32'd0);
      default:                write_legal = 1'b0;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tx_load      = 1'b0;
    tx_nxt       = RESP_NAK;
    write_en     = 1'b0;
    trig_with    = 1'b0;
    trig_without = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_fire) begin
          if (!opcode_known(iRX_DATA)) begin
            state_nxt = ST_RESPOND;
            tx_load   = 1'b1;
          end else if (payload_len(iRX_DATA) == 3'd0) begin
            state_nxt = ST_EXEC;
          end else begin
            state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        // Timeout beats a byte arriving on the same cycle.
        if (gap_expired) begin
          state_nxt = ST_RESPOND;
          tx_load   = 1'b1;
        end else if (rx_fire && ({1'b0, byte_idx} == payload_len(opcode) - 3'd1)) begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_write) begin
          state_nxt = ST_RESPOND;
          tx_load   = 1'b1;
          if (!iSEQ_BUSY && write_legal) begin
            write_en = 1'b1;
            tx_nxt   = RESP_ACK;
          end
        end else if (is_start) begin
          if (iSEQ_BUSY) begin
            state_nxt = ST_RESPOND;
            tx_load   = 1'b1;
          end else begin
            state_nxt = ST_START;
          end
        end else begin
          state_nxt = ST_RESPOND;
          tx_load   = 1'b1;
          tx_nxt    = {iSEQ_BUSY, 1'b0, iFRAME_ID};
        end
      end
      ST_START: begin
        trig_with    = (opcode == OP_START_GALVO);
        trig_without = (opcode != OP_START_GALVO);
        state_nxt    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (iSEQ_BUSY) begin
          state_nxt = ST_RESPOND;
          tx_load   = 1'b1;
          tx_nxt    = RESP_ACK;
        end else if (wait_cnt == 2'(BUSY_WAIT - 1)) begin
          state_nxt = ST_RESPOND;
          tx_load   = 1'b1;
        end
      end
      ST_RESPOND: begin
        if (iTX_READY) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      opcode     <= 8'd0;
      payload    <= 32'd0;
      byte_idx   <= 2'd0;
      wait_cnt   <= 2'd0;
      tx_dat     <= 8'd0;
      cam_ms     <= DEFAULT_CAM_MS;
      galvo_ms   <= DEFAULT_GALVO_MS;
      num_images <= DEFAULT_NUM_IMAGES;
      cycles     <= DEFAULT_CYCLES;
      galvo_pos  <= DEFAULT_GALVO_POS;
    end else begin
      if ((state == ST_IDLE) && rx_fire) begin
        opcode   <= iRX_DATA;
        payload  <= 32'd0;
        byte_idx <= 2'd0;
      end
      if ((state == ST_PAYLOAD) && rx_fire && !gap_expired) begin
        payload[{byte_idx, 3'b000} +: 8] <= iRX_DATA;
        byte_idx                         <= byte_idx + 2'd1;
      end
      if (state == ST_START) begin
        wait_cnt <= 2'd0;
      end else if (state == ST_WAIT_BUSY) begin
        wait_cnt <= wait_cnt + 2'd1;
      end
      if (tx_load) begin
        tx_dat <= tx_nxt;
      end
      if (write_en) begin
        case (opcode)
          OP_CAM_MS:     cam_ms     <= payload[7:0];
          OP_GALVO_MS:   galvo_ms   <= payload[7:0];
          OP_NUM_IMAGES: num_images <= payload[6:0];
          OP_CYCLES:     cycles     <= payload[15:0];
          OP_GALVO_POS:  galvo_pos  <= payload;
          default:       ;
        endcase
      end
    end
  end

endmodule
